button_event_arbiter: RTL and testbench

Multi-channel button front end for the mixer's user controls. It debounces `NUM_BUTTONS` raw inputs on a shared sample tick and turns each debounced edge into a pending event. A round-robin arbiter then serialises the pending events onto one valid/ready event port consumed by the control FSM. It replaces one-debouncer-per-button instantiation with a single scheduled sampler and one event stream.

---
 rtl/button_event_arbiter.sv | 182 ++++++++++++++++++
 tb/tb_button_event_arbiter.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/button_event_arbiter.sv
// Debounces NUM_BUTTONS raw inputs on one shared sample tick and serialises debounced edges round-robin onto a valid/ready event port.
// Define BUTTON_EVENT_RELEASE_EN to also report releases; otherwise only presses raise events and event_press reads 1.
module button_event_arbiter #(
  parameter int NUM_BUTTONS = 4,
  parameter int HIST_LEN    = 8,
  parameter int TICK_DIV    = 1000,
  localparam int ID_W       = $clog2(NUM_BUTTONS)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [NUM_BUTTONS-1:0] buttons,
  output logic [NUM_BUTTONS-1:0] debounced,
  output logic                   event_valid,
  input  logic                   event_ready,
  output logic [ID_W-1:0]        event_id,
  output logic                   event_press,
  output logic                   overflow,
  input  logic                   overflow_clr
);

  localparam int CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  logic [CNT_W-1:0]                     tick_cnt_q, tick_cnt_d;
  logic                                 tick;
  logic [NUM_BUTTONS-1:0][HIST_LEN-1:0] hist_q, hist_d;
  logic [NUM_BUTTONS-1:0]               deb_q, deb_d;
  logic [NUM_BUTTONS-1:0]               rise, new_edge;
  logic [NUM_BUTTONS-1:0]               pend_q, pend_d;
  logic [NUM_BUTTONS-1:0]               gnt_oh;
  logic [ID_W-1:0]                      ptr_q, ptr_d;
  logic [ID_W-1:0]                      grant_idx;
  logic                                 grant_vld;
  logic                                 load, take, drop;
  logic                                 ev_valid_q, ev_valid_d;
  logic [ID_W-1:0]                      ev_id_q, ev_id_d;
  logic                                 overflow_q, overflow_d;
`ifdef BUTTON_EVENT_RELEASE_EN
  logic [NUM_BUTTONS-1:0]               fall;
  logic [NUM_BUTTONS-1:0]               pend_type_q, pend_type_d;
  logic                                 ev_press_q, ev_press_d;
`endif

  assign tick       = (tick_cnt_q == CNT_W'(TICK_DIV - 1));
  assign tick_cnt_d = tick ? '0 : tick_cnt_q + 1'b1;

  // Debounce decision looks at the history including the sample taken this tick.
  always_comb begin
    hist_d = hist_q;
    deb_d  = deb_q;
    for (int i = 0; i < NUM_BUTTONS; i++) begin
      if (tick) begin
        hist_d[i] = {hist_q[i][HIST_LEN-2:0], buttons[i]};
        if (&hist_d[i]) begin
          deb_d[i] = 1'b1;
        end else if (~|hist_d[i]) begin
          deb_d[i] = 1'b0;
        end
      end
    end
  end

  assign rise = deb_d & ~deb_q;
`ifdef BUTTON_EVENT_RELEASE_EN
  assign fall     = deb_q & ~deb_d;
  assign new_edge = rise | fall;
`else
  assign new_edge = rise;
`endif

  // Round-robin search starts one past the last granted channel.
  always_comb begin
    int idx;
    idx       = 0;
    grant_vld = 1'b0;
    grant_idx = '0;
    gnt_oh    = '0;
    for (int k = 1; k <= NUM_BUTTONS; k++) begin
      idx = (int'(ptr_q) + k) % NUM_BUTTONS;
      if (!grant_vld && pend_q[idx]) begin
        grant_vld = 1'b1;
        grant_idx = ID_W'(idx);
      end
    end
    if (grant_vld) begin
      gnt_oh[grant_idx] = 1'b1;
    end
  end

  assign load = !ev_valid_q || event_ready;
  assign take = load && grant_vld;

  always_comb begin
    pend_d = pend_q;
    drop   = 1'b0;
`ifdef BUTTON_EVENT_RELEASE_EN
    pend_type_d = pend_type_q;
`endif
    for (int i = 0; i < NUM_BUTTONS; i++) begin
      if (take && gnt_oh[i]) begin
        pend_d[i] = 1'b0;
      end
      // A slot being granted this cycle frees up in time to take the new edge.
      if (new_edge[i]) begin
        if (pend_q[i] && !(take && gnt_oh[i])) begin
          drop = 1'b1;
        end else begin
          pend_d[i] = 1'b1;
`ifdef BUTTON_EVENT_RELEASE_EN
          pend_type_d[i] = rise[i];
`endif
        end
      end
    end
    overflow_d = overflow_q;
    if (overflow_clr) begin
      overflow_d = 1'b0;
    end
    if (drop) begin
      overflow_d = 1'b1;
    end
  end

  always_comb begin
    ev_valid_d = ev_valid_q;
    ev_id_d    = ev_id_q;
    ptr_d      = ptr_q;
`ifdef BUTTON_EVENT_RELEASE_EN
    ev_press_d = ev_press_q;
`endif
    if (load) begin
      ev_valid_d = grant_vld;
      if (grant_vld) begin
        ev_id_d = grant_idx;
        ptr_d   = grant_idx;
`ifdef BUTTON_EVENT_RELEASE_EN
        ev_press_d = pend_type_q[grant_idx];
`endif
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      tick_cnt_q <= '0;
      hist_q     <= '0;
      deb_q      <= '0;
      pend_q     <= '0;
      ptr_q      <= ID_W'(NUM_BUTTONS - 1);
      ev_valid_q <= 1'b0;
      ev_id_q    <= '0;
      overflow_q <= 1'b0;
`ifdef BUTTON_EVENT_RELEASE_EN
      pend_type_q <= '0;
      ev_press_q  <= 1'b0;
`endif
    end else begin
      tick_cnt_q <= tick_cnt_d;
      hist_q     <= hist_d;
      deb_q      <= deb_d;
      pend_q     <= pend_d;
      ptr_q      <= ptr_d;
      ev_valid_q <= ev_valid_d;
      ev_id_q    <= ev_id_d;
      overflow_q <= overflow_d;
`ifdef BUTTON_EVENT_RELEASE_EN
      pend_type_q <= pend_type_d;
      ev_press_q  <= ev_press_d;
`endif
    end
  end

  assign debounced   = deb_q;
  assign event_valid = ev_valid_q;
  assign event_id    = ev_id_q;
  assign overflow    = overflow_q;
`ifdef BUTTON_EVENT_RELEASE_EN
  assign event_press = ev_press_q;
`else
  assign event_press = 1'b1;
`endif

endmodule

// File: tb/tb_button_event_arbiter.sv
// Directed bench for button_event_arbiter (4 buttons, 4-deep history, tick every 4 clocks).
// Expected events are queued as stimulus is applied and popped at each handshake.
module tb_button_event_arbiter;

`ifdef BUTTON_EVENT_RELEASE_EN
  localparam bit REL_EN = 1'b1;
`else
  localparam bit REL_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] buttons = 4'b0000;
  logic [3:0] debounced;
  logic       event_valid;
  logic       event_ready = 1'b0;
  logic [1:0] event_id;
  logic       event_press;
  logic       overflow;
  logic       overflow_clr = 1'b0;

  int total = 0;
  int bad   = 0;

  logic [2:0] exp_q[$];
  logic       prev_hold  = 1'b0;
  logic [1:0] prev_id    = 2'd0;
  logic       prev_press = 1'b0;

  button_event_arbiter #(
    .NUM_BUTTONS(4),
    .HIST_LEN   (4),
    .TICK_DIV   (4)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .buttons     (buttons),
    .debounced   (debounced),
    .event_valid (event_valid),
    .event_ready (event_ready),
    .event_id    (event_id),
    .event_press (event_press),
    .overflow    (overflow),
    .overflow_clr(overflow_clr)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push_press(input logic [1:0] id);
    exp_q.push_back({1'b1, id});
  endtask

  task automatic push_rel(input logic [1:0] id);
    if (REL_EN) exp_q.push_back({1'b0, id});
  endtask

  // Handshake scoreboard plus hold-stability watch, sampled mid-cycle.
  always @(negedge clk) begin
    logic [31:0] want;
    if (reset) begin
      prev_hold = 1'b0;
    end else begin
      if (prev_hold) begin
        check("hold_valid", {31'd0, event_valid}, 32'd1);
        check("hold_id", {30'd0, event_id}, {30'd0, prev_id});
        check("hold_press", {31'd0, event_press}, {31'd0, prev_press});
      end
      if (event_valid && event_ready) begin
        if (exp_q.size() > 0) want = {29'd0, exp_q.pop_front()};
        else want = 32'hEE;
        check("evt_press_id", {29'd0, event_press, event_id}, want);
      end
      prev_hold  = event_valid && !event_ready;
      prev_id    = event_id;
      prev_press = event_press;
    end
  end

  initial begin
    // Reset values with arbitrary buttons applied.
    reset = 1'b1;
    buttons = 4'b1011;
    cyc(3);
    check("rst_deb", {28'd0, debounced}, 32'd0);
    check("rst_valid", {31'd0, event_valid}, 32'd0);
    check("rst_id", {30'd0, event_id}, 32'd0);
    check("rst_press", {31'd0, event_press}, {31'd0, !REL_EN});
    check("rst_ovf", {31'd0, overflow}, 32'd0);

    // Single press of button 2 held from release; ticks at edges 4,8,12,16.
    buttons = 4'b0100;
    event_ready = 1'b1;
    reset = 1'b0;
    push_press(2'd2);
    cyc(1);
    check("rel1_deb", {28'd0, debounced}, 32'd0);
    check("rel1_valid", {31'd0, event_valid}, 32'd0);
    check("rel1_press", {31'd0, event_press}, {31'd0, !REL_EN});
    cyc(14);
    check("e15_deb", {28'd0, debounced}, 32'd0);
    cyc(1);
    check("e16_deb", {28'd0, debounced}, 32'h4);
    check("e16_valid", {31'd0, event_valid}, 32'd0);
    cyc(1);
    check("e17_valid", {31'd0, event_valid}, 32'd1);
    check("e17_id", {30'd0, event_id}, 32'd2);
    check("e17_press", {31'd0, event_press}, 32'd1);
    cyc(1);
    check("e18_valid", {31'd0, event_valid}, 32'd0);

    // Release button 2: debounced falls on the fourth tick after release.
    buttons = 4'b0000;
    push_rel(2'd2);
    cyc(13);
    check("e31_deb", {28'd0, debounced}, 32'h4);
    cyc(1);
    check("e32_deb", {28'd0, debounced}, 32'd0);
    cyc(1);
    check("e33_rel_valid", {31'd0, event_valid}, {31'd0, REL_EN});
    check("e33_ovf", {31'd0, overflow}, 32'd0);
    cyc(2);

    // Glitch on button 1 lasting three ticks, applied right after a reset.
    reset = 1'b1;
    cyc(2);
    reset = 1'b0;
    buttons = 4'b0010;
    cyc(12);
    buttons = 4'b0000;
    cyc(24);
    check("glitch_deb", {28'd0, debounced}, 32'd0);
    check("glitch_valid", {31'd0, event_valid}, 32'd0);
    check("glitch_ovf", {31'd0, overflow}, 32'd0);

    // Round robin: 0,1,3 together with the consumer stalled.
    event_ready = 1'b0;
    buttons = 4'b1011;
    push_press(2'd0);
    push_press(2'd1);
    push_press(2'd3);
    cyc(24);
    check("rr_hold_valid", {31'd0, event_valid}, 32'd1);
    check("rr_hold_id", {30'd0, event_id}, 32'd0);
    event_ready = 1'b1;
    cyc(1);
    check("rr_second_id", {30'd0, event_id}, 32'd1);
    check("rr_second_valid", {31'd0, event_valid}, 32'd1);
    cyc(1);
    check("rr_third_id", {30'd0, event_id}, 32'd3);
    cyc(1);
    check("rr_drained", {31'd0, event_valid}, 32'd0);
    buttons = 4'b0000;
    push_rel(2'd0);
    push_rel(2'd1);
    push_rel(2'd3);
    cyc(24);
    // Pointer sits at 3, so 0 wins over 3.
    buttons = 4'b1001;
    push_press(2'd0);
    push_press(2'd3);
    cyc(24);
    buttons = 4'b0000;
    push_rel(2'd0);
    push_rel(2'd3);
    cyc(24);
    check("rr_deb_idle", {28'd0, debounced}, 32'd0);

    // Overflow: register busy with button 1, button 0 pending, then 0 released.
    event_ready = 1'b0;
    buttons = 4'b0010;
    push_press(2'd1);
    cyc(24);
    check("ovf_busy_id", {30'd0, event_id}, 32'd1);
    buttons = 4'b0011;
    push_press(2'd0);
    cyc(24);
    check("ovf_pend_no_ovf", {31'd0, overflow}, 32'd0);
    buttons = 4'b0010;
    cyc(24);
    check("ovf_set", {31'd0, overflow}, {31'd0, REL_EN});
    check("ovf_deb", {28'd0, debounced}, 32'h2);
    event_ready = 1'b1;
    cyc(1);
    check("ovf_next_valid", {31'd0, event_valid}, 32'd1);
    check("ovf_next_id", {30'd0, event_id}, 32'd0);
    check("ovf_next_press", {31'd0, event_press}, 32'd1);
    cyc(1);
    check("ovf_no_release", {31'd0, event_valid}, 32'd0);
    check("ovf_sticky", {31'd0, overflow}, {31'd0, REL_EN});
    overflow_clr = 1'b1;
    cyc(1);
    overflow_clr = 1'b0;
    check("ovf_cleared", {31'd0, overflow}, 32'd0);
    buttons = 4'b0000;
    push_rel(2'd1);
    cyc(24);

    check("sb_drained", exp_q.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
